bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.

---
 rtl/bin2bcd_seq.sv | 151 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock, saturating at 10^DIGITS-1.
// Define BIN2BCD_AUTO_EN for free-running mode (start ignored, a conversion begins on every idle cycle).
module bin2bcd_seq #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [4*DIGITS-1:0]   bcd_value_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_PASS = CW'(WIDTH - 1);

  function automatic logic [63:0] max_decimal(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  function automatic logic [BW-1:0] all_nines();
    logic [BW-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'h9;
    end
    return r;
  endfunction

  localparam logic [63:0]   MAX_DEC = max_decimal(DIGITS);
  localparam logic [BW-1:0] NINES   = all_nines();

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [BW-1:0]     bcd_q, bcd_d;

  logic              start_req;
  logic [BW-1:0]     acc_adj;
  logic [BW-1:0]     acc_sh;
  logic [WIDTH-1:0]  sr_sh;

`ifdef BIN2BCD_AUTO_EN
  // Free-running: start has no effect, every idle cycle launches a conversion.
  assign start_req = start_i | 1'b1;
`else
  assign start_req = start_i;
`endif

  // One double-dabble pass: correct every digit >= 5, then shift the next binary bit in.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_sh = {acc_adj[BW-2:0], sr_q[WIDTH-1]};
    sr_sh  = sr_q << 1;
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          sr_d       = bin_in_i;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (64'(bin_in_i) > MAX_DEC);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = sr_sh;
        acc_d = acc_sh;
        cnt_d = cnt_q + CW'(1);
        // Result is published on the edge entering DONE so it coincides with the done pulse.
        if (cnt_q == LAST_PASS) begin
          state_d = S_DONE;
          bcd_d   = ovf_pend_q ? NINES : acc_sh;
          ovf_d   = ovf_pend_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;
  assign bcd_value_o = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
`timescale 1ns/1ps
// Self-checking bench for bin2bcd_seq: arithmetic reference model checked every cycle plus directed literal checks.
module tb_bin2bcd_seq;
  localparam int W = 20;
  localparam int D = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  bin_in;
  logic          busy, done, overflow;
  logic [4*D-1:0] bcd;

  always #10 clk = ~clk;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .bin_in_i    (bin_in),
    .busy_o      (busy),
    .done_o      (done),
    .overflow_o  (overflow),
    .bcd_value_o (bcd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division, saturated to six nines.
  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    if (v > 999999) return 24'h999999;
    x = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  int            m_rem  = 0;
  int unsigned   m_val  = 0;
  logic          m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  logic [23:0]   m_bcd  = '0;
  bit            chk_en = 1'b0;
  logic          req;

`ifdef BIN2BCD_AUTO_EN
  assign req = 1'b1;
`else
  assign req = start;
`endif

  // Timing model: a request accepted in idle keeps the block busy for W+1 cycles, last one is done.
  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_bcd = '0; m_ovf = 1'b0;
    end else if (m_rem == 0) begin
      if (req) begin
        m_val = int'(bin_in);
        m_rem = W + 1;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) begin
        m_bcd = to_bcd(m_val);
        m_ovf = (m_val > 999999);
      end
    end
    m_busy = (m_rem != 0);
    m_done = (m_rem == 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", 64'(busy), 64'(m_busy));
      chk("model_done", 64'(done), 64'(m_done));
      chk("model_ovf",  64'(overflow), 64'(m_ovf));
      chk("model_bcd",  64'(bcd), 64'(m_bcd));
    end
  end

  task automatic do_conv(input logic [W-1:0] v, input logic [23:0] exp_bcd, input logic exp_ovf);
    int n;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("conv_latency", 64'(n), 64'd21);
    chk("conv_bcd", 64'(bcd), 64'(exp_bcd));
    chk("conv_ovf", 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    int dones;
    int n;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf",  64'(overflow), 64'd0);
    chk("rst_bcd",  64'(bcd), 64'd0);

`ifdef BIN2BCD_AUTO_EN
    bin_in = 20'd42;
    reset  = 1'b0;
    n = 0;
    while (bcd !== 24'h000042 && n < 44) begin
      @(negedge clk);
      n++;
    end
    chk("auto_bcd", 64'(bcd), 64'h000042);
    n = 0;
    while (!done && n < 30) begin @(negedge clk); n++; end
    @(negedge clk);
    n = 1;
    while (!done && n < 30) begin @(negedge clk); n++; end
    chk("auto_period", 64'(n), 64'd22);
    repeat (30) @(negedge clk);
`else
    reset = 1'b0;
    @(negedge clk);
    do_conv(20'd123456, 24'h123456, 1'b0);
    do_conv(20'd0,      24'h000000, 1'b0);
    do_conv(20'd999999, 24'h999999, 1'b0);
    do_conv(20'd1000000, 24'h999999, 1'b1);
    do_conv(20'hFFFFF,  24'h999999, 1'b1);
    do_conv(20'd654321, 24'h654321, 1'b0);

    // Starts at E0+3 and E0+21 land while busy; bin_in changes mid-run.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd314159;
    dones  = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (done) dones++;
      start = (k == 2 || k == 20);
      if (k == 5) bin_in = 20'd777777;
    end
    chk("busy_start_dones", 64'(dones), 64'd1);
    chk("busy_start_bcd", 64'(bcd), 64'h314159);

    // Reset sampled at E0+10 aborts the conversion.
    start  = 1'b1;
    bin_in = 20'd271828;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (k == 9);
    end
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bcd",  64'(bcd), 64'd0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);

    // start held high: back-to-back conversions every W+2 cycles.
    start  = 1'b1;
    bin_in = 20'd42;
    n = 0;
    dones = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    chk("held_start_dones", 64'(dones), 64'd2);
    chk("held_start_bcd", 64'(bcd), 64'h000042);
    repeat (30) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
